// File: rtl/mult_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_engine_pkg
//  Purpose  : Shared constants for the iterative shift-add multiplier:
//             FSM state encoding, default operand width, step-counter width.
//  Revision : 1.0  initial release
// ============================================================================
package mult_engine_pkg;

    // FSM state encoding (2-bit)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Default operand width; the product is twice this
    localparam int DEFAULT_WIDTH = 8;

    // Step counter width for a given operand width (never below one bit)
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/shift_add_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_step
//  Purpose  : One combinational shift-add iteration: conditionally add the
//             shifted multiplicand, shift multiplicand left and multiplier
//             right, and flag when the remaining multiplier bits are zero.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_a,
    output logic [WIDTH-1:0]   o_b,
    output logic               o_b_zero
);

    // Single partial-product step; b_zero looks at the post-shift multiplier
    always_comb begin
        o_acc    = i_b[0] ? (i_acc + i_a) : i_acc;
        o_a      = i_a << 1;
        o_b      = i_b >> 1;
        o_b_zero = (o_b == '0);
    end

endmodule
`default_nettype wire

// File: rtl/mult_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mult_engine
//  Purpose  : Iterative shift-add unsigned multiplier, engine side of a
//             start/done handshake. engDone is a level held until the next
//             start; product is only updated on the completing edge.
//  Config   : MULT_EARLY_TERM_EN - finish as soon as the remaining multiplier
//             bits are all zero (latency = position of highest set bit of B,
//             minimum one cycle). Undefined: fixed WIDTH-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module mult_engine
    import mult_engine_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               EngStart,
    input  logic [WIDTH-1:0]   operandA,
    input  logic [WIDTH-1:0]   operandB,
    output logic               engDone,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
`ifdef MULT_EARLY_TERM_EN
    localparam logic          EARLY_TERM = 1'b1;
`else
    localparam logic          EARLY_TERM = 1'b0;
`endif

    logic [1:0]         state_q,   state_d;
    logic [2*WIDTH-1:0] a_reg_q,   a_reg_d;
    logic [WIDTH-1:0]   b_reg_q,   b_reg_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q,    done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] step_a;
    logic [WIDTH-1:0]   step_b;
    logic               step_b_zero;
    logic               last_step;

    shift_add_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .i_acc    (acc_q),
        .i_a      (a_reg_q),
        .i_b      (b_reg_q),
        .o_acc    (step_acc),
        .o_a      (step_a),
        .o_b      (step_b),
        .o_b_zero (step_b_zero)
    );

    // Completion test: counter reaches the final step, or nothing left to add
    always_comb begin
        last_step = (cnt_q == LAST_CNT) || (EARLY_TERM && step_b_zero);
    end

    // Next-state logic; a start request overrides every state, including RUN
    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = done_q;

        if (EngStart) begin
            a_reg_d = {{WIDTH{1'b0}}, operandA};
            b_reg_d = operandB;
            acc_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                end
                RUN: begin
                    acc_d   = step_acc;
                    a_reg_d = step_a;
                    b_reg_d = step_b;
                    cnt_d   = cnt_q + ONE_CNT;
                    if (last_step) begin
                        // Publish the sum including this step's partial product
                        product_d = step_acc;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign engDone = done_q;
    assign busy    = (state_q == RUN);
    assign product = product_q;

endmodule
`default_nettype wire

// File: doc/mult_engine.md
# mult_engine

- Iterative shift-add unsigned multiplier: the engine side of the controller/engine start–done handshake.
- Sits under the main controller. Takes a start pulse or level (`EngStart`) with two operands, runs one partial-product step per clock, then raises `engDone` with a full-width product.
- `engDone` is a level. It stays high until the next start so the controller can poll it at any later cycle.

## Interface
- `WIDTH`, default 8: operand width in bits; product is 2*WIDTH.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `EngStart` input 1: start request, sampled each rising edge.
- `operandA` input WIDTH: multiplicand, captured on the start edge.
- `operandB` input WIDTH: multiplier, captured on the start edge.
- `engDone` output 1: result valid; level.
- `busy` output 1: high while iterating.
- `product` output 2*WIDTH: registered result.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: `engDone`=0, `busy`=0, `product`=0. Internal `a_reg`, `b_reg`, `acc` and `cnt` are all 0.
- Start priority:
  - `EngStart`=1 at any edge, in any state (including RUN and DONE), loads operands and enters RUN.
  - On load: `a_reg`={WIDTH zeros, operandA}, `b_reg`=operandB, `acc`=0, `cnt`=0, `engDone`=0.
  - A start in RUN aborts the current run.
  - A start held for several cycles reloads on every edge. The last sampled operands win.
- RUN, one step per edge with `EngStart`=0:
  - `acc` += `b_reg[0]` ? `a_reg` : 0.
  - `a_reg` shifts left by 1 (2*WIDTH wide, no bit loss).
  - `b_reg` shifts right by 1, zero fill.
  - `cnt` increments.
  - At the step where `cnt`==WIDTH-1: `product` gets the final `acc` value, `engDone`=1, state goes to DONE.
- DONE: holds `product` and `engDone`=1 until a start or reset.
- IDLE: `engDone`=0, `product` holds its last value (0 after reset).
- Arithmetic: all sums are 2*WIDTH bits, unsigned. Overflow is impossible; 255*255=65025 fits in 16 bits.
- Reset mid-run: returns to IDLE at once and clears all registers. No partial `product` is exposed.
- `busy` = (state==RUN).

## Timing
- Call the edge that samples `EngStart`=1 E0.
- `engDone` falls no later than the edge after E0. It is registered low at E0 and already low in the next cycle.
  - This guarantees the controller never sees a stale done two cycles after issuing a start.
- Default build: `engDone` and `product` become valid after edge E0+WIDTH. That is WIDTH cycles of latency, 8 for the default.
- `product` changes only at the completing edge or on reset. It is never glitched by intermediate `acc` values.
- An `EngStart` pulse that lands on the completing edge wins: the new run loads and `engDone` stays 0.

## Configuration
- `MULT_EARLY_TERM_EN`
  - Defined: a RUN step whose post-shift `b_reg` is zero completes on that edge, regardless of `cnt`.
    - Latency becomes max(1, index of the highest set bit of operandB + 1) cycles.
    - operandB=0 completes at E0+1 with `product`=0.
  - Undefined: fixed WIDTH-cycle latency for every operand pair.
- `product` values are identical in both builds.

## Structure
- Shared package `mult_engine_pkg` holds:
  - the state encoding constants IDLE=0, RUN=1, DONE=2 (2-bit);
  - the default WIDTH constant;
  - a `cnt` width constant, clog2(WIDTH).
- One sub-module is natural: `shift_add_step`.
  - Combinational single iteration.
  - Inputs: `acc`, `a_reg`, `b_reg`.
  - Outputs: next `acc`, `a_reg`, `b_reg`, plus a `b_zero` flag used by early termination.
- FSM and registers stay in `mult_engine`.

## Test plan
- Basic run: reset low then high; start with 13 and 11 -> `engDone` rises at E0+8 with `product`=143, `busy` high for cycles E0+1..E0+8.
- Full-scale: start with 255 and 255 -> `product`=65025, then start with 1 and 1 -> `engDone` low at E0+1 and `product`=1 at E0+8.
- Restart in RUN: start with 7 and 9, then start again at E0+3 with 3 and 5 -> single completion at the new E0+8 with `product`=15; 63 is never shown.
- Held start: `EngStart` high for 3 cycles, operands 2×3, then 6×4, then 10×10 -> `product`=100 eight edges after the last high edge.
- Reset mid-run: assert `reset` low at E0+4 of 12×12 -> immediate IDLE with `engDone`=0 and `product`=0, and no completion afterwards.
- Early termination (build with `MULT_EARLY_TERM_EN`): 200×3 -> `engDone` at E0+2 with `product`=600; 9×0 -> `engDone` at E0+1 with `product`=0. Without the macro, both take 8 cycles and give the same values.
